sextium_mem_arbiter: RTL and testbench

Shares the single synchronous memory port of the Sextium III core between the CPU controller (instruction fetch, LOAD, STORE, CONST) and a host port used by the program loader/debugger. CPU requests win by default. A starvation counter guarantees the host forward progress, and a host lock lets the loader own memory for whole-program transfers. The block issues one memory command per cycle, routes read data back to the requester one cycle later, and drives a stall signal the CPU controller uses to hold its state.

---
 rtl/sextium_pkg.sv | 26 ++
 rtl/sextium_mem_arbiter_if.sv | 61 ++++++
 rtl/sextium_rd_return.sv | 48 ++++
 rtl/sextium_mem_arbiter.sv | 97 +++++++++
 tb/tb_sextium_mem_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sextium_pkg.sv
// sextium_pkg
//   Shared definitions for the Sextium III memory arbiter slice:
//   default bus widths, arbiter state encoding, read-return tag encoding
//   and the debug struct that exposes the arbiter state.
package sextium_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;  // four 4-bit instructions per word

  typedef enum logic {
    ST_ARB  = 1'b0,  // memory shared, CPU wins by default
    ST_LOCK = 1'b1   // host owns memory exclusively
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_HOST = 2'd2
  } rd_tag_t;

  typedef struct packed {
    arb_state_t state;
    logic [3:0] starve_cnt;
  } arb_dbg_t;

endpackage

// File: rtl/sextium_mem_arbiter_if.sv
// sextium_mem_arbiter_if
//   Bundle of the CPU port, host port and memory command port.
//   Modports:
//     slave  - arbiter view: takes requests, drives grants/read data and
//              the memory command, receives mem_rdata.
//     master - requester/memory view (CPU controller, host, memory).
//
// Handshake: a requester raises req with we/addr/wdata and holds all of
// them stable until it sees gnt high at a rising edge; that edge is the
// one and only transfer. gnt may rise in the same cycle as req. For a
// read, rvalid is high for exactly the one cycle following the transfer
// and rdata is valid only while rvalid is high (0 otherwise).
interface sextium_mem_arbiter_if #(
  parameter int ADDR_W = sextium_pkg::DEF_ADDR_W,
  parameter int DATA_W = sextium_pkg::DEF_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_owned;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata, host_owned,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata, host_owned,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/sextium_rd_return.sv
// sextium_rd_return
//   Remembers which port issued the read in the previous cycle and routes
//   the memory's read data back to that port for one cycle.
//   Ports:
//     clock, reset        - rising-edge clock, synchronous active-low reset
//     cpu_rd, host_rd     - a read command was issued for that port this cycle
//     mem_rdata           - memory read data (one cycle after the command)
//     cpu_rvalid/rdata    - CPU read return
//     host_rvalid/rdata   - host read return
module sextium_rd_return
  import sextium_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              host_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  rd_tag_t tag;

  // At most one of cpu_rd/host_rd is high: the arbiter grants one port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag <= TAG_NONE;
    end else if (cpu_rd) begin
      tag <= TAG_CPU;
    end else if (host_rd) begin
      tag <= TAG_HOST;
    end else begin
      tag <= TAG_NONE;
    end
  end

  // Gating with reset drops a return that was already tagged when reset
  // arrives, so every output reads 0 while reset is held.
  assign cpu_rvalid  = reset & (tag == TAG_CPU);
  assign host_rvalid = reset & (tag == TAG_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/sextium_mem_arbiter.sv
// sextium_mem_arbiter
//   Shares the single synchronous memory port between the CPU controller
//   and the host (loader/debugger). CPU wins by default; a starvation
//   counter forces the host through after STARVE_LIMIT denied cycles; the
//   host can lock memory for exclusive use.
//   Ports:
//     clock, reset - rising-edge clock, synchronous active-low reset
//     bus          - CPU/host/memory bundle (slave view)
//     dbg          - current arbiter state and starvation count
module sextium_mem_arbiter
  import sextium_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4  // 1..15
) (
  input  logic                  clock,
  input  logic                  reset,
  sextium_mem_arbiter_if.slave  bus,
  output arb_dbg_t              dbg
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic       cpu_gnt;
  logic       host_gnt;

  // Grants are combinational (zero-latency); all outputs are held at 0
  // while reset is asserted.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (reset) begin
      if (state == ST_LOCK) begin
        host_gnt = bus.host_req;
      end else if (bus.host_req && (!bus.cpu_req || starve_cnt == LIMIT)) begin
        host_gnt = 1'b1;
      end else begin
        cpu_gnt = bus.cpu_req;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_ARB;
      starve_cnt <= '0;
    end else begin
      state <= bus.host_lock ? ST_LOCK : ST_ARB;
      // Clearing in LOCK means the count starts from 0 on re-entry to ARB.
      if (state == ST_LOCK || !bus.host_req || host_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.host_gnt   = host_gnt;
  assign bus.cpu_stall  = reset & bus.cpu_req & ~cpu_gnt;
  assign bus.host_owned = reset & (state == ST_LOCK);

  always_comb begin
    bus.mem_en    = cpu_gnt | host_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (host_gnt) begin
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  sextium_rd_return #(.DATA_W(DATA_W)) u_rd_return (
    .clock       (clock),
    .reset       (reset),
    .cpu_rd      (cpu_gnt & ~bus.cpu_we),
    .host_rd     (host_gnt & ~bus.host_we),
    .mem_rdata   (bus.mem_rdata),
    .cpu_rvalid  (bus.cpu_rvalid),
    .cpu_rdata   (bus.cpu_rdata),
    .host_rvalid (bus.host_rvalid),
    .host_rdata  (bus.host_rdata)
  );

  assign dbg.state      = state;
  assign dbg.starve_cnt = starve_cnt;

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// tb_sextium_mem_arbiter
//   Directed bench for sextium_mem_arbiter (STARVE_LIMIT = 4). The driver
//   applies one input vector per cycle and queues the hand-computed
//   control/debug response plus any expected read data; a monitor on the
//   falling edge pops and compares.
module tb_sextium_mem_arbiter;
  import sextium_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sextium_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  arb_dbg_t   dbg;
  logic [4:0] dbg_v;
  assign dbg_v = dbg;

  sextium_mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .dbg   (dbg)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      16'h0010: return 16'h9A3C;
      16'h0020: return 16'h0C0D;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= mem_read(bus.mem_addr);
    end
  end

  // ---------------- scoreboard ----------------
  // ctl = {cpu_gnt, cpu_stall, host_gnt, host_owned, mem_en, mem_we}
  localparam logic [5:0] C_IDLE    = 6'b000000;
  localparam logic [5:0] C_CPU_RD  = 6'b100010;
  localparam logic [5:0] C_HOST_RD = 6'b001010;
  localparam logic [5:0] C_HWR_STL = 6'b011011;  // host write, CPU stalled
  localparam logic [5:0] C_LCK_WR  = 6'b011111;
  localparam logic [5:0] C_LCK_RD  = 6'b011110;
  // dbg = {state, starve_cnt}
  localparam logic [4:0] D_ARB0  = 5'b0_0000;
  localparam logic [4:0] D_LOCK0 = 5'b1_0000;

  logic [10:0] ctl_q[$];
  logic [15:0] cpu_exp_q[$];
  logic [15:0] host_exp_q[$];
  int vectors;
  int miscompares;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [10:0] e;
    logic [5:0]  act;
    if (ctl_q.size() != 0) begin
      e   = ctl_q.pop_front();
      act = {bus.cpu_gnt, bus.cpu_stall, bus.host_gnt, bus.host_owned, bus.mem_en, bus.mem_we};
      chk("ctl", 32'(act), 32'(e[10:5]));
      chk("dbg", 32'(dbg_v), 32'(e[4:0]));
      if (!bus.mem_en) chk("mem_idle", {bus.mem_addr, bus.mem_wdata}, 32'h0);
      if (bus.cpu_rvalid) begin
        chk("cpu_rvalid_expected", 32'(cpu_exp_q.size() != 0), 32'h1);
        if (cpu_exp_q.size() != 0) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp_q.pop_front()));
      end else begin
        chk("cpu_rdata_idle", 32'(bus.cpu_rdata), 32'h0);
      end
      if (bus.host_rvalid) begin
        chk("host_rvalid_expected", 32'(host_exp_q.size() != 0), 32'h1);
        if (host_exp_q.size() != 0) chk("host_rdata", 32'(bus.host_rdata), 32'(host_exp_q.pop_front()));
      end else begin
        chk("host_rdata_idle", 32'(bus.host_rdata), 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst,
                       input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
                       input logic hl, input logic [5:0] ectl, input logic [4:0] edbg);
    @(posedge clock);
    #1;
    reset          = rst;
    bus.cpu_req    = cr;
    bus.cpu_we     = cw;
    bus.cpu_addr   = ca;
    bus.cpu_wdata  = cd;
    bus.host_req   = hr;
    bus.host_we    = hw;
    bus.host_addr  = ha;
    bus.host_wdata = hd;
    bus.host_lock  = hl;
    ctl_q.push_back({ectl, edbg});
  endtask

  task automatic idle(input logic [5:0] ectl, input logic [4:0] edbg);
    drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, ectl, edbg);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset          = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_lock  = 1'b0;
    repeat (2) @(posedge clock);

    // Reset held with a CPU request pending: every output stays 0.
    drive(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, C_IDLE, D_ARB0);

    // CPU read of 0x0010: same-cycle grant, data next cycle.
    cpu_exp_q.push_back(16'h9A3C);
    drive(1, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, C_CPU_RD, D_ARB0);
    idle(C_IDLE, D_ARB0);

    // Continuous CPU reads against a host write: host denied 4 cycles.
    for (int i = 0; i < 4; i++) begin
      cpu_exp_q.push_back(16'h0C0D);
      drive(1, 1, 0, 16'h0020, 16'h0, 1, 1, 16'h0100, 16'h1234, 0, C_CPU_RD, {1'b0, 4'(i)});
    end
    drive(1, 1, 0, 16'h0020, 16'h0, 1, 1, 16'h0100, 16'h1234, 0, C_HWR_STL, 5'b0_0100);
    cpu_exp_q.push_back(16'h0C0D);
    drive(1, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 0, C_CPU_RD, D_ARB0);
    host_exp_q.push_back(16'h1234);
    drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0100, 16'h0, 0, C_HOST_RD, D_ARB0);

    // Lock taken during a granted CPU read; that read still returns.
    cpu_exp_q.push_back(16'h9A3C);
    drive(1, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, C_CPU_RD, D_ARB0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 16'h0010, 16'h0, 1, 1, 16'(i), 16'hA000 + 16'(i), 1, C_LCK_WR, D_LOCK0);
    end

    // Lock dropped while both request: host finishes in LOCK, then CPU wins.
    host_exp_q.push_back(16'hA002);
    drive(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0002, 16'h0, 0, C_LCK_RD, D_LOCK0);
    cpu_exp_q.push_back(16'h9A3C);
    drive(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0003, 16'h0, 0, C_CPU_RD, D_ARB0);
    host_exp_q.push_back(16'hA003);
    drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0003, 16'h0, 0, C_HOST_RD, 5'b0_0001);

    // Alternating reads, no contention.
    cpu_exp_q.push_back(16'hA000);
    drive(1, 1, 0, 16'h0000, 16'h0, 0, 0, 16'h0, 16'h0, 0, C_CPU_RD, D_ARB0);
    host_exp_q.push_back(16'hA001);
    drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0001, 16'h0, 0, C_HOST_RD, D_ARB0);
    cpu_exp_q.push_back(16'h1234);
    drive(1, 1, 0, 16'h0100, 16'h0, 0, 0, 16'h0, 16'h0, 0, C_CPU_RD, D_ARB0);
    host_exp_q.push_back(16'hA003);
    drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0003, 16'h0, 0, C_HOST_RD, D_ARB0);

    // Granted host read immediately followed by reset: no return.
    drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0, 0, C_HOST_RD, D_ARB0);
    drive(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0010, 16'h0, 1, C_IDLE, D_ARB0);
    idle(C_IDLE, D_ARB0);
    idle(C_IDLE, D_ARB0);

    @(negedge clock);
    #1;
    chk("cpu_reads_outstanding", 32'(cpu_exp_q.size()), 32'h0);
    chk("host_reads_outstanding", 32'(host_exp_q.size()), 32'h0);
    chk("ctl_outstanding", 32'(ctl_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
